timer_sequencer: RTL

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

---
 rtl/stopwatch_pkg.sv | 39 +++
 rtl/alarm_timer.sv | 47 ++++
 rtl/timer_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencer: state encoding,
// button decode, BCD digit maxima and the 9:59.9 count-up limit.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EDIT  = 3'd1,
        ST_ARMED = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4,
        ST_ALARM = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        BTN_NONE  = 3'd0,
        BTN_CLEAR = 3'd1,
        BTN_SET   = 3'd2,
        BTN_GO    = 3'd3,
        BTN_INC   = 3'd4
    } btn_t;

    localparam logic [1:0] SEL_MIN = 2'd0;
    localparam logic [1:0] SEL_ST  = 2'd1;
    localparam logic [1:0] SEL_SU  = 2'd2;

    localparam logic [3:0] MIN_MAX = 4'd9;
    localparam logic [3:0] ST_MAX  = 4'd5;
    localparam logic [3:0] SU_MAX  = 4'd9;

    localparam logic [3:0] LIMIT_MIN    = 4'd9;
    localparam logic [3:0] LIMIT_ST     = 4'd5;
    localparam logic [3:0] LIMIT_SU     = 4'd9;
    localparam logic [3:0] LIMIT_TENTHS = 4'd9;

    function automatic logic [3:0] bcd_wrap_inc(input logic [3:0] d, input logic [3:0] dmax);
        return (d >= dmax) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// Alarm duration and blink counters: alarm starts high on start, toggles every
// BLINK_TICKS ticks, and done fires on the ALARM_TICKS-th tick.
module alarm_timer #(
    parameter int ALARM_TICKS = 100,
    parameter int BLINK_TICKS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic tick,
    output logic alarm,
    output logic done
);

    localparam int AW = $clog2(ALARM_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic          active;
    logic [AW-1:0] alarm_cnt;
    logic [BW-1:0] blink_cnt;

    assign done = active && tick && (alarm_cnt == AW'(ALARM_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            active    <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
            blink_cnt <= '0;
        end else if (start) begin
            active    <= 1'b1;
            alarm     <= 1'b1;
            alarm_cnt <= '0;
            blink_cnt <= '0;
        end else if (active && tick) begin
            alarm_cnt <= alarm_cnt + AW'(1);
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                alarm     <= ~alarm;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Stopwatch/timer control FSM: decodes buttons, edits the BCD preset and
// issues registered one-cycle commands to the stopwatch datapath.
module timer_sequencer
    import stopwatch_pkg::*;
#(
    parameter int ALARM_TICKS = 100,
    parameter int BLINK_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_100ms,
    input  logic       go_btn,
    input  logic       set_btn,
    input  logic       inc_btn,
    input  logic       clear_btn,
    input  logic [3:0] digit_min,
    input  logic [3:0] digit_st,
    input  logic [3:0] digit_su,
    input  logic [3:0] digit_tenths,
    output logic       start_pulse,
    output logic       stop_pulse,
    output logic       clear_pulse,
    output logic       load_pulse,
    output logic       count_down,
    output logic [3:0] preset_min,
    output logic [3:0] preset_st,
    output logic [3:0] preset_su,
    output logic [1:0] edit_sel,
    output logic       edit_active,
    output logic       alarm,
    output logic       ovf,
    output logic [2:0] state
);

    state_t     state_q, state_nx;
    btn_t       btn;
    logic [3:0] pre_min_nx, pre_st_nx, pre_su_nx;
    logic [1:0] sel_nx;
    logic       cd_nx, ovf_nx;
    logic       start_nx, stop_nx, clear_nx, load_nx;
    logic       preset_zero, at_zero, at_limit;
    logic       alarm_start, alarm_abort, alarm_done;

    assign state       = state_q;
    assign edit_active = (state_q == ST_EDIT);

    assign preset_zero = (preset_min == 4'd0) && (preset_st == 4'd0) && (preset_su == 4'd0);
    assign at_zero     = (digit_min == 4'd0) && (digit_st == 4'd0) &&
                         (digit_su == 4'd0) && (digit_tenths == 4'd0);
    assign at_limit    = (digit_min == LIMIT_MIN) && (digit_st == LIMIT_ST) &&
                         (digit_su == LIMIT_SU) && (digit_tenths == LIMIT_TENTHS);

    // Only the highest-priority pressed button is considered in a cycle.
    always_comb begin
        btn = BTN_NONE;
        if (clear_btn)    btn = BTN_CLEAR;
        else if (set_btn) btn = BTN_SET;
        else if (go_btn)  btn = BTN_GO;
        else if (inc_btn) btn = BTN_INC;
    end

    always_comb begin
        state_nx   = state_q;
        pre_min_nx = preset_min;
        pre_st_nx  = preset_st;
        pre_su_nx  = preset_su;
        sel_nx     = edit_sel;
        cd_nx      = count_down;
        ovf_nx     = ovf;
        start_nx   = 1'b0;
        stop_nx    = 1'b0;
        clear_nx   = 1'b0;
        load_nx    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn == BTN_GO) begin
                    state_nx = ST_RUN;
                    cd_nx    = 1'b0;
                    start_nx = 1'b1;
                end else if (btn == BTN_SET) begin
                    state_nx = ST_EDIT;
                    sel_nx   = SEL_MIN;
                end
            end
            ST_EDIT: begin
                case (btn)
                    BTN_CLEAR: begin
                        pre_min_nx = 4'd0;
                        pre_st_nx  = 4'd0;
                        pre_su_nx  = 4'd0;
                        sel_nx     = SEL_MIN;
                        state_nx   = ST_IDLE;
                    end
                    BTN_SET: begin
                        if (edit_sel == SEL_SU) begin
                            load_nx  = 1'b1;
                            cd_nx    = 1'b1;
                            sel_nx   = SEL_MIN;
                            state_nx = ST_ARMED;
                        end else begin
                            sel_nx = edit_sel + 2'd1;
                        end
                    end
                    BTN_INC: begin
                        case (edit_sel)
                            SEL_MIN: pre_min_nx = bcd_wrap_inc(preset_min, MIN_MAX);
                            SEL_ST:  pre_st_nx  = bcd_wrap_inc(preset_st, ST_MAX);
                            default: pre_su_nx  = bcd_wrap_inc(preset_su, SU_MAX);
                        endcase
                    end
                    default: ;
                endcase
            end
            ST_ARMED: begin
                if (btn == BTN_CLEAR) begin
                    clear_nx = 1'b1;
                    cd_nx    = 1'b0;
                    state_nx = ST_IDLE;
                end else if (btn == BTN_GO && !preset_zero) begin
                    start_nx = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                // Terminal conditions only apply when no button is acted on.
                if (btn == BTN_CLEAR) begin
                    stop_nx  = 1'b1;
                    clear_nx = 1'b1;
                    ovf_nx   = 1'b0;
                    cd_nx    = 1'b0;
                    state_nx = ST_IDLE;
                end else if (btn == BTN_GO) begin
                    stop_nx  = 1'b1;
                    state_nx = ST_PAUSE;
                end else if (count_down && at_zero) begin
                    stop_nx  = 1'b1;
                    state_nx = ST_ALARM;
                end else if (!count_down && at_limit) begin
                    stop_nx  = 1'b1;
                    ovf_nx   = 1'b1;
                    state_nx = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (btn == BTN_CLEAR) begin
                    clear_nx = 1'b1;
                    ovf_nx   = 1'b0;
                    cd_nx    = 1'b0;
                    state_nx = ST_IDLE;
                end else if (btn == BTN_GO && !ovf) begin
                    start_nx = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (btn != BTN_NONE || alarm_done) begin
                    clear_nx = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign alarm_start = (state_nx == ST_ALARM) && (state_q != ST_ALARM);
    assign alarm_abort = (state_q == ST_ALARM) && (state_nx != ST_ALARM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            preset_min  <= 4'd0;
            preset_st   <= 4'd0;
            preset_su   <= 4'd0;
            edit_sel    <= SEL_MIN;
            count_down  <= 1'b0;
            ovf         <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            clear_pulse <= 1'b0;
            load_pulse  <= 1'b0;
        end else begin
            state_q     <= state_nx;
            preset_min  <= pre_min_nx;
            preset_st   <= pre_st_nx;
            preset_su   <= pre_su_nx;
            edit_sel    <= sel_nx;
            count_down  <= cd_nx;
            ovf         <= ovf_nx;
            start_pulse <= start_nx;
            stop_pulse  <= stop_nx;
            clear_pulse <= clear_nx;
            load_pulse  <= load_nx;
        end
    end

    alarm_timer #(
        .ALARM_TICKS (ALARM_TICKS),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_alarm_timer (
        .clk   (clk),
        .rst   (rst),
        .start (alarm_start),
        .abort (alarm_abort),
        .tick  (tick_100ms),
        .alarm (alarm),
        .done  (alarm_done)
    );

endmodule
